// File: rtl/node_mem_pkg.sv
// Shared types and constants for the node neighbour/knownCH memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package node_mem_pkg;

    localparam int MEM_DEPTH  = 2048;
    localparam int MEM_WIDTH  = 8;
    localparam int WORD_WIDTH = 16;

    // Requester slots on the arbiter ports
    localparam int REQ_QUPD  = 0;
    localparam int REQ_ROUTE = 1;
    localparam int REQ_TX    = 2;

    // Word access sequencer: two byte cycles, one capture cycle, one ack cycle
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_CAP  = 3'd3,
        ST_ACK  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/node_mem_arbiter_rr_picker.sv
// Round-robin picker: first requester at or after rr_ptr, optional fixed priority for requester 0.
// Latency: combinational.
// Backpressure: none; the caller decides when to consume the pick.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    input  logic               prio0,
    output logic [NUM_REQ-1:0] pick,
    output logic [PTR_W-1:0]   pick_idx,
    output logic               pick_vld
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; requester 0 overrides when prio0
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!pick_vld && req[idx]) begin
                pick[idx] = 1'b1;
                pick_idx  = idx;
                pick_vld  = 1'b1;
            end
        end
        if (prio0 && req[0]) begin
            pick     = '0;
            pick[0]  = 1'b1;
            pick_idx = '0;
            pick_vld = 1'b1;
        end
    end

endmodule

// File: rtl/node_mem_arbiter.sv
// Arbitrates a byte-wide single-port memory between word requesters; NODE_MEM_ARB_PRIO_EN gives requester 0 priority.
// Latency: ack 4 cycles after the IDLE sample edge; 5-cycle word spacing unlocked, 4 cycles within a locked burst.
// Backpressure: req is held until ack; a grant cannot be aborted, and locked bursts are capped at MAX_BURST words.
module node_mem_arbiter
    import node_mem_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = $clog2(MEM_DEPTH),
    parameter int WORD_W    = WORD_WIDTH,
    parameter int MEM_W     = MEM_WIDTH,
    parameter int MAX_BURST = 8
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*(ADDR_W-1)-1:0] waddr,
    input  logic [NUM_REQ*WORD_W-1:0]     wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            ack,
    output logic [WORD_W-1:0]             rdata,
    output logic                          busy,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [MEM_W-1:0]              mem_wdata,
    input  logic [MEM_W-1:0]              mem_rdata
);

    localparam int AW    = ADDR_W - 1;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t            state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [PTR_W-1:0]      g_q, g_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic [WORD_W-1:0]     rdata_q, rdata_d;

    logic [AW-1:0]         cur_waddr;
    logic [WORD_W-1:0]     cur_wdata;
    logic                  cur_we;
    logic                  cur_lock;
    logic                  cur_req;
    logic                  burst_go;

    logic [NUM_REQ-1:0]    pick;
    logic [PTR_W-1:0]      pick_idx;
    logic                  pick_vld;
    logic                  prio0;

`ifdef NODE_MEM_ARB_PRIO_EN
    assign prio0 = 1'b1;
`else
    assign prio0 = 1'b0;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req      (req),
        .rr_ptr   (rr_ptr_q),
        .prio0    (prio0),
        .pick     (pick),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    // Route the granted requester's command fields to the sequencer
    always_comb begin
        cur_waddr = '0;
        cur_wdata = '0;
        cur_we    = 1'b0;
        cur_lock  = 1'b0;
        cur_req   = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt_q[r]) begin
                cur_waddr = waddr[r*AW +: AW];
                cur_wdata = wdata[r*WORD_W +: WORD_W];
                cur_we    = we[r];
                cur_lock  = lock[r];
                cur_req   = req[r];
            end
        end
    end

    // Next-state and output decode of the word sequencer
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        g_d         = g_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        rdata_d     = rdata_q;
        burst_go    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        ack         = '0;
        busy        = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick;
                    g_d     = pick_idx;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                mem_en    = 1'b1;
                mem_we    = cur_we;
                mem_addr  = {cur_waddr, 1'b0};
                mem_wdata = cur_wdata[MEM_W-1:0];
                state_d   = ST_HI;
            end
            ST_HI: begin
                // Low byte read issued in LO returns now
                mem_en    = 1'b1;
                mem_we    = cur_we;
                mem_addr  = {cur_waddr, 1'b1};
                mem_wdata = cur_wdata[WORD_W-1:MEM_W];
                if (!cur_we) begin
                    rdata_d[MEM_W-1:0] = mem_rdata;
                end
                state_d   = ST_CAP;
            end
            ST_CAP: begin
                if (!cur_we) begin
                    rdata_d[WORD_W-1:MEM_W] = mem_rdata;
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                ack      = gnt_q;
                burst_go = cur_lock && cur_req && (burst_cnt_q < CNT_W'(MAX_BURST-1));
`ifdef NODE_MEM_ARB_PRIO_EN
                // A pending requester 0 breaks any other requester's burst
                if (req[REQ_QUPD] && (g_q != PTR_W'(REQ_QUPD))) begin
                    burst_go = 1'b0;
                end
`endif
                if (burst_go) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    state_d     = ST_LO;
                end else begin
                    gnt_d       = '0;
                    burst_cnt_d = '0;
                    rr_ptr_d    = (g_q == PTR_W'(NUM_REQ-1)) ? '0 : g_q + PTR_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, grant, fairness pointer, burst count and read word
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            g_q         <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            g_q         <= g_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            rdata_q     <= rdata_d;
        end
    end

    assign gnt   = gnt_q;
    assign rdata = rdata_q;

endmodule
